// File: rtl/uart_pkg.sv
// Shared UART definitions: the default bit timing used by the Transmitter
// and its scheduler, and the scheduler state encoding.
package uart_pkg;

    localparam int UART_CLKS_PER_BIT = 10416;  // 100 MHz clk, 9600 baud
    localparam int UART_FRAME_BITS   = 10;     // start + 8 data + stop

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } sched_state_t;

    // Larger of two integers, used when sizing shared counters.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past the last
// granted index and wraps, so the most recently served requester has the
// lowest priority.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    logic [IW-1:0] idx_s;

    // Walk the requesters from last_grant+1 with wrap-around; first hit wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = last_grant;
        any     = 1'b0;
        idx_s   = '0;
        for (int k = 1; k <= N; k++) begin
            idx_s = IW'((int'(last_grant) + k) % N);
            if (!any && req[idx_s]) begin
                any          = 1'b1;
                gnt_idx      = idx_s;
                gnt[idx_s]   = 1'b1;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART Transmitter between NUM_REQ byte producers. The
// Transmitter has no done flag, so this block times each frame itself:
// Transmit is held high with stable data for exactly one frame, followed by
// a forced idle gap before the next round-robin grant.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int FRAME_BITS   = UART_FRAME_BITS,
    parameter int GAP_CYCLES   = 2,
    parameter int IW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_transmit,
    output logic [7:0]           tx_data,
    output logic                 busy,
    output logic [IW-1:0]        grant_id,
    output logic [15:0]          frames_sent
);

    localparam int FRAME_CYCLES = FRAME_BITS * CLKS_PER_BIT;
    // One counter times both the frame and the gap, so size it for the longer.
    localparam int CW = max_int(1, $clog2(max_int(FRAME_CYCLES, GAP_CYCLES)));
    localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

    sched_state_t  state_r;
    sched_state_t  state_nx;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nx;
    logic [7:0]    data_r;
    logic [IW-1:0] grant_r;
    logic [15:0]   frames_r;
    logic          tx_transmit_r;
    logic          busy_r;

    logic [NUM_REQ-1:0] gnt_s;
    logic [IW-1:0]      gnt_idx_s;
    logic               any_s;
    logic               accept_s;
    logic               frame_done_s;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_arb (
        .req        (req_valid),
        .last_grant (grant_r),
        .gnt        (gnt_s),
        .gnt_idx    (gnt_idx_s),
        .any        (any_s)
    );

    // Next-state and counter logic; acceptance only happens in IDLE with enable.
    always_comb begin
        state_nx     = state_r;
        cnt_nx       = cnt_r;
        accept_s     = 1'b0;
        frame_done_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (enable && any_s) begin
                    accept_s = 1'b1;
                    state_nx = SEND;
                    cnt_nx   = '0;
                end else begin
                    state_nx = IDLE;
                end
            end
            SEND: begin
                if (cnt_r == FRAME_LAST) begin
                    state_nx     = GAP;
                    cnt_nx       = '0;
                    frame_done_s = 1'b1;
                end else begin
                    cnt_nx = cnt_r + CW'(1);
                end
            end
            GAP: begin
                if (cnt_r == GAP_LAST) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt_r + CW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // State and frame/gap counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nx;
            cnt_r   <= cnt_nx;
        end
    end

    // Latch the winner's byte and index on acceptance; later data changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r  <= 8'h00;
            grant_r <= IW'(NUM_REQ - 1);
        end else if (accept_s) begin
            data_r  <= req_data[8*gnt_idx_s +: 8];
            grant_r <= gnt_idx_s;
        end else begin
            data_r  <= data_r;
            grant_r <= grant_r;
        end
    end

    // Count fully completed frames; wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frames_r <= 16'h0000;
        end else if (frame_done_s) begin
            frames_r <= frames_r + 16'd1;
        end else begin
            frames_r <= frames_r;
        end
    end

    // Registered Transmit and busy, decoded from the upcoming state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_transmit_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            tx_transmit_r <= (state_nx == SEND);
            busy_r        <= (state_nx != IDLE);
        end
    end

    // Ready must be combinational so a falling enable suppresses the grant in the same cycle.
    assign req_ready   = accept_s ? gnt_s : '0;
    assign tx_transmit = tx_transmit_r;
    assign tx_data     = data_r;
    assign busy        = busy_r;
    assign grant_id    = grant_r;
    assign frames_sent = frames_r;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler with a 40-cycle frame
// (CLKS_PER_BIT=4, FRAME_BITS=10) and a 2-cycle gap.
module tb_uart_tx_scheduler;

    localparam int NUM_REQ = 4;
    localparam int FRAME   = 40;
    localparam int SPACING = 43;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_transmit;
    logic [7:0]  tx_data;
    logic        busy;
    logic [1:0]  grant_id;
    logic [15:0] frames_sent;

    uart_tx_scheduler #(
        .NUM_REQ      (4),
        .CLKS_PER_BIT (4),
        .FRAME_BITS   (10),
        .GAP_CYCLES   (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_transmit (tx_transmit),
        .tx_data     (tx_data),
        .busy        (busy),
        .grant_id    (grant_id),
        .frames_sent (frames_sent)
    );

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] id;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   skip_len   = 1'b0;
    bit   spacing_en = 1'b0;
    bit   have_last  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on each Transmit rise, checks frame length and spacing.
    logic prev_tx = 1'b0;
    int   hi_cnt  = 0;
    int   last_rise = 0;
    always @(negedge clk) begin
        if (tx_transmit && !prev_tx) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_frame", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("tx_data", 32'(tx_data), 32'(e.data));
                chk("grant_id", 32'(grant_id), 32'(e.id));
            end
            if (spacing_en && have_last) chk("rise_spacing", 32'(cyc - last_rise), 32'(SPACING));
            last_rise = cyc;
            have_last = 1'b1;
            hi_cnt = 1;
        end else if (tx_transmit) begin
            hi_cnt++;
        end else if (prev_tx) begin
            if (skip_len) skip_len = 1'b0;
            else chk("frame_len", 32'(hi_cnt), 32'(FRAME));
        end
        prev_tx = tx_transmit;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 4'b0000;
        tick(3);
        rst = 1'b0;
    endtask

    // Poll until the DUT offers ready; a timeout counts as a failed comparison.
    task automatic wait_ready(input logic [3:0] exp_ready, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (req_ready != 4'b0000) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) chk({name, "_timeout"}, 32'd0, 32'd1);
        else chk(name, 32'(req_ready), 32'(exp_ready));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        if (!ok) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] order [5];
        order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        rst = 1'b1;
        enable = 1'b0;
        req_valid = 4'b0000;
        req_data = 32'h0000_0000;
        tick(2);
        // Reset state
        chk("rst_tx_transmit", 32'(tx_transmit), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'h00);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd3);
        chk("rst_frames", 32'(frames_sent), 32'd0);
        rst = 1'b0;
        tick(1);

        // Single request from requester 2
        enable = 1'b1;
        req_data = 32'h00AB_0000;
        req_valid = 4'b0100;
        exp_q.push_back('{data: 8'hAB, id: 2'd2});
        #1;
        chk("single_ready_same_cycle", 32'(req_ready), 32'(4'b0100));
        tick(1);
        req_valid = 4'b0000;
        req_data = 32'h0011_0000;
        #1;
        chk("single_transmit_next", 32'(tx_transmit), 32'd1);
        chk("single_no_ready_in_send", 32'(req_ready), 32'd0);
        tick(20);
        chk("single_data_held", 32'(tx_data), 32'hAB);
        wait_idle();
        chk("single_frames", 32'(frames_sent), 32'd1);
        chk("single_grant_id", 32'(grant_id), 32'd2);

        // Full contention from reset: strict rotation 0,1,2,3,0
        do_reset();
        req_data = 32'hDDCC_BBAA;
        req_valid = 4'b1111;
        have_last = 1'b0;
        spacing_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back('{data: req_data[8*order[k] +: 8], id: order[k]});
        end
        for (int k = 0; k < 5; k++) begin
            wait_ready(4'b0001 << order[k], "rotation_ready");
            if (k == 4) req_valid = 4'b0000;
        end
        wait_idle();
        spacing_en = 1'b0;
        chk("rotation_frames", 32'(frames_sent), 32'd5);

        // Fairness: req3 arriving during req0's frame wins the next grant
        req_data = 32'h3300_0001;
        req_valid = 4'b0001;
        exp_q.push_back('{data: 8'h01, id: 2'd0});
        exp_q.push_back('{data: 8'h33, id: 2'd3});
        exp_q.push_back('{data: 8'h01, id: 2'd0});
        wait_ready(4'b0001, "fair_first");
        tick(10);
        req_valid = 4'b1001;
        wait_ready(4'b1000, "fair_req3_next");
        req_valid = 4'b0001;
        wait_ready(4'b0001, "fair_req0_after");
        req_valid = 4'b0000;
        wait_idle();

        // Enable gating
        enable = 1'b0;
        req_data = 32'h0000_0042;
        req_valid = 4'b0001;
        tick(5);
        chk("en_off_ready", 32'(req_ready), 32'd0);
        chk("en_off_transmit", 32'(tx_transmit), 32'd0);
        enable = 1'b1;
        exp_q.push_back('{data: 8'h42, id: 2'd0});
        wait_ready(4'b0001, "en_on_ready");
        tick(5);
        enable = 1'b0;
        wait_idle();
        tick(5);
        chk("en_off_stays_idle", 32'(busy), 32'd0);
        chk("en_off_no_ready", 32'(req_ready), 32'd0);
        req_valid = 4'b0000;
        enable = 1'b1;

        // Reset in the middle of a frame
        req_data = 32'h005A_0000;
        req_valid = 4'b0100;
        exp_q.push_back('{data: 8'h5A, id: 2'd2});
        wait_ready(4'b0100, "abort_ready");
        req_valid = 4'b0000;
        tick(17);
        skip_len = 1'b1;
        rst = 1'b1;
        #1;
        chk("abort_transmit_async", 32'(tx_transmit), 32'd0);
        chk("abort_frames", 32'(frames_sent), 32'd0);
        tick(1);
        rst = 1'b0;
        req_data = 32'h0000_1E00;
        req_valid = 4'b0010;
        exp_q.push_back('{data: 8'h1E, id: 2'd1});
        wait_ready(4'b0010, "after_abort_ready");
        req_valid = 4'b0000;
        wait_idle();
        chk("after_abort_frames", 32'(frames_sent), 32'd1);

        // frames_sent wrap
        @(negedge clk);
        force dut.frames_r = 16'hFFFF;
        @(negedge clk);
        release dut.frames_r;
        tick(1);
        chk("wrap_preload", 32'(frames_sent), 32'hFFFF);
        req_data = 32'h7700_0000;
        req_valid = 4'b1000;
        exp_q.push_back('{data: 8'h77, id: 2'd3});
        wait_ready(4'b1000, "wrap_ready");
        req_valid = 4'b0000;
        wait_idle();
        chk("wrap_frames", 32'(frames_sent), 32'h0000);

        tick(3);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
